// File: rtl/iterative_shifter_if.sv
// iterative_shifter_if: request/result bus between a shift requester and the iterative shifter.
interface iterative_shifter_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
);
  logic               start_i;
  logic [DATA_W-1:0]  data_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [2:0]         mode_i;
  logic               busy_o;
  logic               done_o;
  logic [DATA_W-1:0]  data_o;
  modport master (output start_i, data_i, shamt_i, mode_i, input busy_o, done_o, data_o);
  modport slave  (input start_i, data_i, shamt_i, mode_i, output busy_o, done_o, data_o);
endinterface

// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle shift/rotate unit moving at most STEP bit positions per clock.
module iterative_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int STEP    = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  iterative_shifter_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [2:0] M_SRA = 3'd0;
  localparam logic [2:0] M_SLL = 3'd1;
  localparam logic [2:0] M_SRL = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;
  // one extra bit so STEP == DATA_W still fits the remaining-count width
  localparam logic [SHAMT_W:0] STEP_C = STEP[SHAMT_W:0];
  localparam logic [SHAMT_W:0] DATA_C = DATA_W[SHAMT_W:0];
  logic [0:0]         state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [SHAMT_W:0]   rem_q, rem_d;
  logic [2:0]         mode_q, mode_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SHAMT_W:0]   k, kc;
  logic signed [DATA_W-1:0] acc_s;
  logic [DATA_W-1:0]  sra, shifted;
  always_comb begin
    k = rem_q > STEP_C ? STEP_C : rem_q;
    kc = DATA_C - k;
    acc_s = acc_q;
    // kept apart from the mode mux so the arithmetic shift stays signed
    sra = acc_s >>> k;
    shifted = mode_q == M_SRA ? sra :
              mode_q == M_SLL ? acc_q << k :
              mode_q == M_SRL ? acc_q >> k :
              mode_q == M_ROL ? (acc_q << k) | (acc_q >> kc) :
              mode_q == M_ROR ? (acc_q >> k) | (acc_q << kc) : acc_q;
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    rem_d = rem_q;
    mode_d = mode_q;
    done_d = 1'b0;
    data_d = data_q;
    if (state_q == S_IDLE) begin
      if (bus.start_i) begin
        state_d = S_RUN;
        acc_d = bus.data_i;
        rem_d = bus.mode_i > M_ROR ? '0 : {1'b0, bus.shamt_i};
        mode_d = bus.mode_i;
      end
    end else if (rem_q != '0) begin
      acc_d = shifted;
      rem_d = rem_q - k;
    end else begin
      state_d = S_IDLE;
      done_d = 1'b1;
      data_d = acc_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      acc_q <= '0;
      rem_q <= '0;
      mode_q <= '0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      mode_q <= mode_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end
  assign bus.busy_o = state_q == S_RUN;
  assign bus.done_o = done_q;
  assign bus.data_o = data_q;
endmodule
